// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_share_arbiter
//  Purpose  : Round-robin arbiter sharing one iterative shift-add multiplier
//             between two requesters (signed/unsigned, 2*WIDTH-bit product).
//  Revision : 1.0  initial release
// ============================================================================
module mul_share_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iReq0,
    input  logic [WIDTH-1:0]   iA0,
    input  logic [WIDTH-1:0]   iB0,
    input  logic               iSigned0,
    input  logic               iReq1,
    input  logic [WIDTH-1:0]   iA1,
    input  logic [WIDTH-1:0]   iB1,
    input  logic               iSigned1,
    output logic               oGrant0,
    output logic               oGrant1,
    output logic               oDone0,
    output logic               oDone1,
    output logic [2*WIDTH-1:0] oResult,
    output logic               oBusy
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_owner;
    logic               r_lastGrant;
    logic               r_negate;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_addend;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_result;

    logic               w_start;
    logic               w_pick1;
    logic [WIDTH-1:0]   w_selA;
    logic [WIDTH-1:0]   w_selB;
    logic               w_selSigned;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_accNext;
    logic [2*WIDTH-1:0] w_product;

    // On contention the requester that was not granted last wins.
    assign w_start     = iReq0 | iReq1;
    assign w_pick1     = iReq1 & (~iReq0 | ~r_lastGrant);
    assign w_selA      = w_pick1 ? iA1 : iA0;
    assign w_selB      = w_pick1 ? iB1 : iB0;
    assign w_selSigned = w_pick1 ? iSigned1 : iSigned0;

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    assign w_magA = (w_selSigned & w_selA[WIDTH-1]) ? (-w_selA) : w_selA;
    assign w_magB = (w_selSigned & w_selB[WIDTH-1]) ? (-w_selB) : w_selB;
    assign w_neg  = w_selSigned & (w_selA[WIDTH-1] ^ w_selB[WIDTH-1]);

    assign w_accNext = r_acc + (r_mcand[0] ? r_addend : '0);
    assign w_product = r_negate ? (-w_accNext) : w_accNext;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_nextState = c_RUN;
            c_RUN:   if (r_cnt == c_LAST) w_nextState = c_DONE;
            c_DONE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_negate    <= 1'b0;
            r_mcand     <= '0;
            r_addend    <= '0;
            r_acc       <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_owner     <= w_pick1;
                        r_lastGrant <= w_pick1;
                        r_negate    <= w_neg;
                        r_mcand     <= w_magA;
                        r_addend    <= {{WIDTH{1'b0}}, w_magB};
                        r_acc       <= '0;
                        r_cnt       <= '0;
                    end
                end
                c_RUN: begin
                    // One multiplicand bit per cycle, LSB first.
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand >> 1;
                    r_addend <= r_addend << 1;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_result <= w_product;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oGrant0 = (r_state == c_RUN) && (r_cnt == '0) && !r_owner;
    assign oGrant1 = (r_state == c_RUN) && (r_cnt == '0) &&  r_owner;
    assign oDone0  = (r_state == c_DONE) && !r_owner;
    assign oDone1  = (r_state == c_DONE) &&  r_owner;
    assign oBusy   = (r_state != c_IDLE);
    assign oResult = r_result;

endmodule
`default_nettype wire
